// File: rtl/bus_pkg.sv
// Shared definitions for the arbitrated datapath bus: FSM encodings, wait-counter
// sizing and the owner-index width helper.
package bus_pkg;

  localparam logic [0:0] BUS_IDLE = 1'b0;
  localparam logic [0:0] BUS_OWN  = 1'b1;

  localparam int                WAIT_W   = 16;
  localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

  // Owner index width, never narrower than one bit.
  function automatic int owner_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_bus_if.sv
// Bus-side signal bundle for arb_bus; the slave modport is the arbiter's view.
// The debug mirror o_w_disp_out exists only when BUS_DISP_OUT_EN is defined.
interface arb_bus_if
  import bus_pkg::*;
#(
  parameter int p_data_width = 16,
  parameter int p_sources    = 7
);

  localparam int OW = owner_width(p_sources);

  logic [p_sources-1:0]              i_w_req;
  logic [p_sources-1:0]              i_w_lock;
  logic [p_sources*p_data_width-1:0] i_w_data;
  logic [p_sources-1:0]              o_w_gnt;
  logic [OW-1:0]                     o_w_owner;
  logic [p_data_width-1:0]           o_w_bus;
  logic                              o_w_bus_valid;
  logic [WAIT_W-1:0]                 o_w_wait_cnt;
`ifdef BUS_DISP_OUT_EN
  logic [p_data_width-1:0]           o_w_disp_out;
`endif

  modport slave (
    input  i_w_req, i_w_lock, i_w_data,
    output o_w_gnt, o_w_owner, o_w_bus, o_w_bus_valid, o_w_wait_cnt
`ifdef BUS_DISP_OUT_EN
    , output o_w_disp_out
`endif
  );

  modport master (
    output i_w_req, i_w_lock, i_w_data,
    input  o_w_gnt, o_w_owner, o_w_bus, o_w_bus_valid, o_w_wait_cnt
`ifdef BUS_DISP_OUT_EN
    , input o_w_disp_out
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: the first requester scanning upward from
// last_i+1, modulo p_n, wins.
module rr_arbiter #(
  parameter int p_n  = 7,
  parameter int p_iw = 3
) (
  input  logic [p_n-1:0]  req_i,
  input  logic [p_iw-1:0] last_i,
  output logic [p_n-1:0]  gnt_o,
  output logic [p_iw-1:0] idx_o
);

  always_comb begin
    int   cand;
    logic found;
    // NOTE: every variable gets a default before the loop so no path infers a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= p_n; off++) begin
      cand = (int'(last_i) + off) % p_n;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = p_iw'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_bus.sv
// Registered round-robin bus: one owner at a time, locked multi-beat bursts bounded
// by p_max_hold under contention, saturating wait counter. Macro: BUS_DISP_OUT_EN.
module arb_bus
  import bus_pkg::*;
#(
  parameter int p_data_width = 16,
  parameter int p_sources    = 7,
  parameter int p_max_hold   = 4
) (
  input logic      i_w_clk,
  input logic      i_w_reset,
  arb_bus_if.slave bus
);

  localparam int OW = owner_width(p_sources);
  localparam int HW = $clog2(p_max_hold + 1);

  logic [0:0]              state_q, state_d;
  logic [p_sources-1:0]    gnt_q, gnt_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           last_q, last_d;
  logic [p_data_width-1:0] bus_q, bus_d;
  logic                    valid_q, valid_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [HW-1:0]           hold_q, hold_d;

  logic [p_sources-1:0]    arb_gnt;
  logic [OW-1:0]           arb_idx;
  logic [p_sources-1:0]    others;
  logic [p_data_width-1:0] owner_data;
  logic                    owner_req;
  logic                    owner_lock;
  logic                    beat;
  logic                    hold_reached;

  // last_q equals the owner while in OWN, so a releasing owner ranks lowest.
  rr_arbiter #(
    .p_n  (p_sources),
    .p_iw (OW)
  ) u_arb (
    .req_i  (bus.i_w_req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  assign others       = bus.i_w_req & ~gnt_q;
  assign owner_req    = bus.i_w_req[owner_q];
  assign owner_lock   = bus.i_w_lock[owner_q];
  assign owner_data   = bus.i_w_data[int'(owner_q)*p_data_width +: p_data_width];
  assign beat         = (state_q == BUS_OWN) && owner_req;
  assign hold_reached = (int'(hold_q) + 1) >= p_max_hold;

  always_comb begin
    logic release_bus;
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    bus_d       = beat ? owner_data : bus_q;
    valid_d     = beat;
    wait_d      = (|others && wait_q != WAIT_SAT) ? wait_q + 1'b1 : wait_q;
    release_bus = 1'b0;

    if (state_q == BUS_IDLE) begin
      if (|bus.i_w_req) begin
        state_d = BUS_OWN;
        gnt_d   = arb_gnt;
        owner_d = arb_idx;
        last_d  = arb_idx;
        hold_d  = '0;
      end
    end else begin
      if (!owner_req || !owner_lock || (hold_reached && |others)) begin
        release_bus = 1'b1;
      end else if (int'(hold_q) < p_max_hold) begin
        hold_d = hold_q + 1'b1;
      end
    end

    if (release_bus) begin
      hold_d = '0;
      if (|others) begin
        gnt_d   = arb_gnt;
        owner_d = arb_idx;
        last_d  = arb_idx;
      end else begin
        state_d = BUS_IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge i_w_clk) begin
    // NOTE: registers use <= so every update sees the pre-edge values of the others.
    if (i_w_reset) begin
      state_q <= BUS_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(p_sources - 1);
      bus_q   <= '0;
      valid_q <= 1'b0;
      wait_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.o_w_gnt       = gnt_q;
  assign bus.o_w_owner     = owner_q;
  assign bus.o_w_bus       = bus_q;
  assign bus.o_w_bus_valid = valid_q;
  assign bus.o_w_wait_cnt  = wait_q;
`ifdef BUS_DISP_OUT_EN
  assign bus.o_w_disp_out  = bus_q;
`endif

endmodule

// File: tb/tb_arb_bus.sv
// Scoreboard bench for arb_bus: the driver steps a rule-level reference model and
// queues the expected outputs; a negedge monitor pops and compares every cycle.
module tb_arb_bus;

  localparam int W    = 16;
  localparam int N    = 7;
  localparam int MAXH = 4;
  localparam int OW   = (N > 2) ? $clog2(N) : 1;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic [W-1:0]  bus;
    logic          valid;
    logic [15:0]   wait_cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_bus_if #(.p_data_width(W), .p_sources(N)) bus_if ();

  arb_bus #(
    .p_data_width (W),
    .p_sources    (N),
    .p_max_hold   (MAXH)
  ) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .bus       (bus_if)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  // Reference model: ownership expressed as "who holds the bus and for how many locked beats".
  bit          m_busy   = 1'b0;
  int          m_owner  = 0;
  int          m_last   = N - 1;
  int          m_tenure = 0;
  int          m_wait   = 0;
  logic [W-1:0] m_bus   = '0;
  logic        m_valid  = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    d = '0;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
    return d;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                            input logic [N*W-1:0] d, input string tag);
    logic [N-1:0] held;
    logic [N-1:0] waiting;
    logic         beat;
    obs_t         e;
    held = '0;
    if (m_busy) held[m_owner] = 1'b1;
    waiting = rq & ~held;
    if (r) begin
      m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_tenure = 0;
      m_wait = 0; m_bus = '0; m_valid = 1'b0;
    end else begin
      if (waiting != 0 && m_wait < 65535) m_wait++;
      if (!m_busy) begin
        m_valid = 1'b0;
        if (rq != 0) begin
          m_owner = pick(rq, m_last); m_last = m_owner; m_busy = 1'b1; m_tenure = 0;
        end
      end else begin
        beat    = rq[m_owner];
        m_valid = beat;
        if (beat) m_bus = d[m_owner*W +: W];
        if (beat && lk[m_owner]) m_tenure++;
        if (beat && lk[m_owner] && !(m_tenure >= MAXH && waiting != 0)) begin
          // locked owner keeps the bus
        end else if (waiting != 0) begin
          m_owner = pick(rq, m_owner); m_last = m_owner; m_tenure = 0;
        end else begin
          m_busy = 1'b0; m_tenure = 0;
        end
      end
    end
    e.gnt = '0;
    if (m_busy) e.gnt[m_owner] = 1'b1;
    e.owner    = OW'(m_owner);
    e.bus      = m_bus;
    e.valid    = m_valid;
    e.wait_cnt = 16'(m_wait);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got gnt=%b owner=%0d bus=%h valid=%b wait=%0d, expected gnt=%b owner=%0d bus=%h valid=%b wait=%0d",
               name, $time, act.gnt, act.owner, act.bus, act.valid, act.wait_cnt,
               exp.gnt, exp.owner, exp.bus, exp.valid, exp.wait_cnt);
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N*W-1:0] d, input string tag);
    @(negedge clk);
    #1;
    rst             = r;
    bus_if.i_w_req  = rq;
    bus_if.i_w_lock = lk;
    bus_if.i_w_data = d;
    model_step(r, rq, lk, d, tag);
  endtask

  // Monitor: entries are pushed one cycle before the edge they describe.
  initial begin
    obs_t  a;
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {bus_if.o_w_gnt, bus_if.o_w_owner, bus_if.o_w_bus, bus_if.o_w_bus_valid,
             bus_if.o_w_wait_cnt};
        check(t, a, e);
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    rst             = 1'b1;
    bus_if.i_w_req  = '0;
    bus_if.i_w_lock = '0;
    bus_if.i_w_data = '0;

    repeat (2)  apply(1'b1, '0, '0, rand_data(), "reset");
    repeat (10) apply(1'b0, '0, '0, rand_data(), "idle");

    d = rand_data();
    d[2*W +: W] = 16'hBEEF;
    repeat (2) apply(1'b0, 7'b0000100, '0, d, "beef");
    repeat (3) apply(1'b0, '0, '0, rand_data(), "beef_release");

    repeat (9) apply(1'b0, 7'b0101001, '0, rand_data(), "rotate");
    apply(1'b0, '0, '0, rand_data(), "gap");

    apply(1'b1, '0, '0, rand_data(), "reset_hold");
    repeat (5) apply(1'b0, 7'b0010010, 7'b0000010, rand_data(), "hold");
    repeat (3) apply(1'b0, 7'b0010000, '0, rand_data(), "hold_next");

    repeat (3) apply(1'b0, 7'b0001000, 7'b0001000, rand_data(), "lock3");
    apply(1'b1, '1, '1, rand_data(), "mid_reset");
    repeat (3) apply(1'b0, 7'b0100001, '0, rand_data(), "post_reset");

    for (int i = 0; i < 800; i++) begin
      apply($urandom_range(0, 63) == 0, N'($urandom & $urandom | $urandom),
            N'($urandom | $urandom), rand_data(), "random");
    end

    apply(1'b1, '0, '0, rand_data(), "reset_sat");
    repeat (65545) apply(1'b0, '1, '0, rand_data(), "saturate");
    repeat (3) apply(1'b0, '0, '0, rand_data(), "sat_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/arb_bus.md
# arb_bus

Registered, arbitrated datapath bus for the lab CPU. It replaces the wired-OR bus, where every source had to drive zeros when idle. Up to `p_sources` sources raise requests, and a round-robin arbiter grants exactly one owner at a time. The granted source's data is registered and broadcast to all destinations. Multi-beat lock with a bounded hold time and a saturating wait-cycle counter are included for profiling.

## Interface
Parameters:
- `p_data_width`, 16, bus data width in bits.
- `p_sources`, 7, number of requesting sources (≥2).
- `p_max_hold`, 4, maximum consecutive locked beats before a forced rotation (≥1).

Ports:
- `i_w_clk`  in  1  single clock; all state on the rising edge.
- `i_w_reset`  in  1  synchronous, active-high reset.
- `i_w_req`  in  `p_sources`  per-source request, bit k = source k.
- `i_w_lock`  in  `p_sources`  per-source lock; meaningful only for the current owner.
- `i_w_data`  in  `p_sources*p_data_width`  packed source data, source k at `[k*W +: W]`.
- `o_w_gnt`  out  `p_sources`  registered one-hot grant, or all-zero.
- `o_w_owner`  out  `OW`  index of the current owner, `OW = max(1, clog2(p_sources))`.
- `o_w_bus`  out  `p_data_width`  registered bus value broadcast to all destinations.
- `o_w_bus_valid`  out  1  `o_w_bus` holds a beat captured in the previous cycle.
- `o_w_wait_cnt`  out  16  saturating count of cycles in which at least one non-owner request was denied.
- `o_w_disp_out`  out  `p_data_width`  debug mirror; present only with `BUS_DISP_OUT_EN`.

## Operation
- State machine with two states, IDLE and OWN.
- **IDLE:** `o_w_gnt` = 0. If any `i_w_req` is high:
  - Select the first requester scanning upward from `last+1`, modulo `p_sources`.
  - Register a one-hot grant and set `o_w_owner`; `last` <= winner; enter OWN.
- **OWN, beat:** every cycle in which `i_w_req[owner]` is high:
  - `o_w_bus` <= `i_w_data[owner]`.
  - `o_w_bus_valid` <= 1 on the next cycle, otherwise 0.
  - The bus register holds its value when there is no beat.
- **OWN, release.** Evaluated after each cycle:
  - Owner request low: release.
  - Beat with lock low: release after a single beat, even if the request stays high.
  - Beat with lock high: keep ownership and increment `hold_cnt`.
  - `hold_cnt` reaches `p_max_hold` while another request is pending: forced release.
  - A locked owner with no other requesters keeps the bus indefinitely.
- **On release:**
  - If other requests are pending, re-arbitrate in the same cycle. The new grant is valid the next cycle, with no idle gap.
  - A releasing owner whose request is still high competes normally and has the lowest priority.
  - Otherwise go to IDLE with `o_w_gnt` <= 0.
  - `hold_cnt` clears on every ownership change.
- **Wait counter:** increments in every cycle where `i_w_req & ~o_w_gnt` is nonzero. It saturates at 16'hFFFF and does not wrap.
- **Reset values:**
  - State IDLE; `o_w_gnt` = 0; `o_w_owner` = 0.
  - `o_w_bus` = 0; `o_w_bus_valid` = 0; `o_w_wait_cnt` = 0; `hold_cnt` = 0.
  - `last` = `p_sources-1`, so source 0 wins first.
- Reset asserted mid-transfer: the in-flight beat is dropped and all outputs take their reset values on the next edge. Requests seen during reset are ignored.

## Timing
- Request to grant: 1 cycle, with the request sampled in IDLE.
- Beat latency: data presented in a granted cycle appears on `o_w_bus` one cycle later, together with `o_w_bus_valid`.
- Sustained throughput: one beat per cycle for a locked owner. Owner handover costs 0 bus cycles.
- Data sampled from a non-owner is ignored. No OR-ing of sources takes place.
- `o_w_gnt` and `o_w_owner` change only on the clock edge and are never combinational from `i_w_req`.

## Configuration
- `BUS_DISP_OUT_EN` defined:
  - `o_w_disp_out` exists and equals `o_w_bus` combinationally.
  - Used for the board seven-segment display.
- Undefined: the port is absent. No other behaviour changes.

## Structure
- Shared package `bus_pkg` holds:
  - State encodings `BUS_IDLE` = 0 and `BUS_OWN` = 1.
  - Wait counter width (16) and its saturation constant.
  - The owner-index width function.
- Sub-module `rr_arbiter`: combinational rotate-priority pick.
  - Inputs: request vector and `last` pointer.
  - Outputs: one-hot winner and winner index.
  - Instantiated once.

## Test plan
- Reset, then `i_w_req` = 0: all outputs zero for 10 cycles; `o_w_wait_cnt` = 0.
- `req[2]`=1, `lock`=0, `data[2]`=16'hBEEF:
  - Cycle 1: `gnt` = 7'b0000100.
  - Cycle 2: `o_w_bus` = 16'hBEEF with valid=1.
  - Then release to IDLE.
- Requests 0, 3 and 5 held high with lock low: grants rotate 0→3→5→0 on consecutive cycles with no gaps.
- `p_max_hold`=4, source 1 locked, source 4 requesting from the same cycle:
  - Source 1 gets exactly 4 beats, then source 4 is granted.
  - `o_w_wait_cnt` increments once per denied cycle, 5 in total.
- Force `o_w_wait_cnt` to near saturation with constant contention: it stops at 16'hFFFF.
- Assert reset mid-beat: the next cycle shows `o_w_bus` = 0, valid=0, `gnt`=0, and source 0 has first priority afterwards.
